pmp_check_walker: RTL and testbench

Sequential PMP checker: accepts one physical-address access request at a time and walks the PMP entries in index order, one entry per cycle. A single shared address matcher does the matching. The walker returns the lowest-numbered matching entry and an allow/deny decision. It sits between the load/store/fetch request mux and the fault logic, and trades latency for area compared with a fully parallel checker.

---
 rtl/pmp_pkg.sv | 32 +++
 rtl/pmp_addr_check.sv | 27 ++
 rtl/pmp_check_walker.sv | 144 ++++++++++++++
 tb/tb_pmp_check_walker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP encodings: cfg field positions, address-match modes, access types
// and the walker FSM states.
package pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  typedef enum logic [1:0] {
    ACC_R    = 2'd0,
    ACC_W    = 2'd1,
    ACC_X    = 2'd2,
    ACC_RSVD = 2'd3
  } acc_e;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } walk_state_e;

endpackage

// File: rtl/pmp_addr_check.sv
// Single-entry PMP address matcher; the walker time-multiplexes one instance
// across all entries.
module pmp_addr_check
  import pmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  pmp_a_e                mode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] entry_addr_i,
  input  logic [ADDR_WIDTH-1:0] lo_addr_i,
  input  logic [ADDR_WIDTH-1:0] mask_i,
  output logic                  match_o
);

  always_comb begin
    match_o = 1'b0;
    case (mode_i)
      A_TOR:   match_o = (addr_i >= lo_addr_i) && (addr_i < entry_addr_i);
      A_NA4:   match_o = (addr_i == entry_addr_i);
      // Bits cleared in the mask are the "don't care" offset within the region.
      A_NAPOT: match_o = ((addr_i ^ entry_addr_i) & mask_i) == '0;
      default: match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_check_walker.sv
// Sequential PMP checker: walks entries in index order, one per cycle, and
// reports the lowest-numbered match together with an allow/deny decision.
module pmp_check_walker
  import pmp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int PMP_ENTRIES = 16,
  parameter int IDX_W       = $clog2(PMP_ENTRIES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_vld,
  output logic                                   req_rdy,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic [1:0]                             req_acc,
  input  logic                                   req_priv_m,
  input  logic [PMP_ENTRIES-1:0][7:0]            pmp_cfg,
  input  logic [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0] pmp_addr,
  output logic                                   rsp_vld,
  input  logic                                   rsp_rdy,
  output logic                                   rsp_allow,
  output logic                                   rsp_hit,
  output logic [IDX_W-1:0]                       rsp_idx,
  output walk_state_e                            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where vld and rdy are both
  // high; req_rdy depends on state only, and rsp_* hold until rsp_rdy is seen.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

  walk_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  acc_e                  acc_q, acc_d;
  logic                  priv_q, priv_d;
  logic                  allow_q, allow_d;
  logic                  hit_q, hit_d;
  logic [IDX_W-1:0]      ridx_q, ridx_d;

  logic [7:0]            cfg_sel;
  logic [ADDR_WIDTH-1:0] entry_addr, lo_addr, napot_mask;
  logic                  match, acc_bit, allow_hit, allow_miss;
  logic                  cfg_unused;

  assign cfg_sel    = pmp_cfg[idx_q];
  assign cfg_unused = ^cfg_sel[6:5];
  assign entry_addr = pmp_addr[idx_q];
  assign lo_addr    = (idx_q == '0) ? '0 : pmp_addr[idx_q - IDX_W'(1)];
  // The +1 wraps, so an all-ones entry yields a zero mask (whole space).
  assign napot_mask = ~(entry_addr ^ (entry_addr + ADDR_WIDTH'(1)));

  pmp_addr_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
    .mode_i       (pmp_a_e'(cfg_sel[CFG_A_HI:CFG_A_LO])),
    .addr_i       (addr_q),
    .entry_addr_i (entry_addr),
    .lo_addr_i    (lo_addr),
    .mask_i       (napot_mask),
    .match_o      (match)
  );

  always_comb begin
    acc_bit = 1'b0;
    case (acc_q)
      ACC_R:   acc_bit = cfg_sel[CFG_R];
      ACC_W:   acc_bit = cfg_sel[CFG_W];
      ACC_X:   acc_bit = cfg_sel[CFG_X];
      default: acc_bit = 1'b0;
    endcase
  end

  assign allow_hit  = (acc_q != ACC_RSVD) && ((priv_q && !cfg_sel[CFG_L]) || acc_bit);
  assign allow_miss = (acc_q != ACC_RSVD) && priv_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    priv_d  = priv_q;
    allow_d = allow_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          addr_d  = req_addr;
          acc_d   = acc_e'(req_acc);
          priv_d  = req_priv_m;
          idx_d   = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (match) begin
          state_d = RESP;
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          allow_d = allow_hit;
        end else if (idx_q == LAST_IDX) begin
          state_d = RESP;
          hit_d   = 1'b0;
          ridx_d  = '0;
          allow_d = allow_miss;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      acc_q   <= ACC_R;
      priv_q  <= 1'b0;
      allow_q <= 1'b0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
    end
  end

  assign req_rdy   = (state_q == IDLE);
  assign rsp_vld   = (state_q == RESP);
  assign rsp_allow = allow_q;
  assign rsp_hit   = hit_q;
  assign rsp_idx   = ridx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pmp_check_walker.sv
// Scoreboarded bench for pmp_check_walker: a region-based reference model
// predicts hit/idx/allow/latency, and a monitor checks each response.
module tb_pmp_check_walker;
  import pmp_pkg::*;

  localparam int AW = 32;
  localparam int NE = 16;
  localparam int IW = 4;
  localparam int W  = 16 + 8 + 2 + IW;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req_vld = 1'b0;
  logic                    req_rdy;
  logic [AW-1:0]           req_addr = '0;
  logic [1:0]              req_acc = '0;
  logic                    req_priv_m = 1'b0;
  logic [NE-1:0][7:0]      pmp_cfg = '0;
  logic [NE-1:0][AW-1:0]   pmp_addr = '0;
  logic                    rsp_vld;
  logic                    rsp_rdy = 1'b0;
  logic                    rsp_allow;
  logic                    rsp_hit;
  logic [IW-1:0]           rsp_idx;
  walk_state_e             dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic hold_low = 1'b0;
  logic [W-1:0] exp_q[$];

  pmp_check_walker #(.ADDR_WIDTH(AW), .PMP_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr(req_addr), .req_acc(req_acc), .req_priv_m(req_priv_m),
    .pmp_cfg(pmp_cfg), .pmp_addr(pmp_addr), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .rsp_allow(rsp_allow), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rsp_rdy = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry is treated as an address region [base, limit); first region
  // containing the address wins.
  function automatic logic [W-1:0] model(input logic [AW-1:0] a, input logic [1:0] acc,
                                         input logic pm, input logic [15:0] accept);
    logic [63:0] lo, hi, size, base;
    logic [7:0]  c;
    logic        m, allow;
    int          t;
    for (int k = 0; k < NE; k++) begin
      c = pmp_cfg[k];
      m = 1'b0;
      case (c[4:3])
        2'd1: begin
          lo = (k == 0) ? 64'd0 : {32'd0, pmp_addr[k-1]};
          hi = {32'd0, pmp_addr[k]};
          m  = ({32'd0, a} >= lo) && ({32'd0, a} < hi);
        end
        2'd2: m = (a == pmp_addr[k]);
        2'd3: begin
          t = 0;
          while (t < AW && pmp_addr[k][t]) t++;
          if (t == AW) m = 1'b1;
          else begin
            size = 64'd1 << (t + 1);
            base = {32'd0, pmp_addr[k]} & ~(size - 64'd1);
            m    = ({32'd0, a} >= base) && ({32'd0, a} < base + size);
          end
        end
        default: m = 1'b0;
      endcase
      if (m) begin
        if (acc == 2'd3)          allow = 1'b0;
        else if (pm && !c[7])     allow = 1'b1;
        else                      allow = c[acc];
        return {accept, 8'(k + 1), allow, 1'b1, IW'(k)};
      end
    end
    allow = (acc == 2'd3) ? 1'b0 : pm;
    return {accept, 8'(NE), allow, 1'b0, IW'(0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [AW-1:0] a, input logic [1:0] acc, input logic pm,
                       input logic push);
    int n = 0;
    @(negedge clk);
    while (!req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req_rdy=%0b required=1", req_rdy);
      return;
    end
    req_addr   = a;
    req_acc    = acc;
    req_priv_m = pm;
    req_vld    = 1'b1;
    if (push) exp_q.push_back(model(a, acc, pm, 16'(cyc + 1)));
    @(posedge clk);
    #1 req_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_rdy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic clear_cfg();
    pmp_cfg  = '0;
    pmp_addr = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          held_vld = 1'b0;
  logic          held_allow, held_hit;
  logic [IW-1:0] held_idx;
  logic [W-1:0]  cur;

  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else if (rsp_vld) begin
      if (!held_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp hit=%0b idx=%0d required=no response", rsp_hit, rsp_idx);
        end else begin
          cur = exp_q.pop_front();
          chk("latency", 32'(16'(cyc) - cur[29:14]), 32'(cur[13:6]));
          chk("rsp_hit", 32'(rsp_hit), 32'(cur[4]));
          chk("rsp_idx", 32'(rsp_idx), 32'(cur[3:0]));
          chk("rsp_allow", 32'(rsp_allow), 32'(cur[5]));
        end
        held_allow = rsp_allow;
        held_hit   = rsp_hit;
        held_idx   = rsp_idx;
      end else begin
        chk("stable_allow", 32'(rsp_allow), 32'(held_allow));
        chk("stable_hit", 32'(rsp_hit), 32'(held_hit));
        chk("stable_idx", 32'(rsp_idx), 32'(held_idx));
        chk("req_rdy_in_resp", 32'(req_rdy), 32'd0);
      end
      held_vld = !rsp_rdy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_rdy", 32'(req_rdy), 32'd1);
    chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("reset_rsp_allow", 32'(rsp_allow), 32'd0);
    chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("reset_rsp_idx", 32'(rsp_idx), 32'd0);

    // All entries off: miss after a full walk.
    clear_cfg();
    issue(32'h1000, 2'd0, 1'b0, 1'b1);
    issue(32'h1000, 2'd0, 1'b1, 1'b1);
    issue(32'h1000, 2'd3, 1'b1, 1'b1);
    drain();

    // TOR window [0x100, 0x200) on entry 3, read-only.
    pmp_addr[2] = 32'h100;
    pmp_addr[3] = 32'h200;
    pmp_cfg[3]  = 8'h09;
    issue(32'h1FF, 2'd0, 1'b0, 1'b1);
    issue(32'h1FF, 2'd1, 1'b0, 1'b1);
    issue(32'h200, 2'd0, 1'b0, 1'b1);
    issue(32'h100, 2'd0, 1'b0, 1'b1);
    issue(32'h0FF, 2'd0, 1'b0, 1'b1);

    // Backpressure: response must hold while rsp_rdy stays low.
    drain();
    hold_low = 1'b1;
    issue(32'h150, 2'd0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_vld_seen", 32'(rsp_vld), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
    end
    hold_low = 1'b0;
    drain();

    // Overlap priority: NA4 on entry 2 inside NAPOT region of entry 5.
    clear_cfg();
    pmp_addr[5] = 32'h1007;
    pmp_cfg[5]  = 8'h19;
    pmp_addr[2] = 32'h1004;
    pmp_cfg[2]  = 8'h14;
    issue(32'h1004, 2'd2, 1'b0, 1'b1);
    issue(32'h1008, 2'd2, 1'b0, 1'b1);
    issue(32'h100F, 2'd0, 1'b0, 1'b1);
    issue(32'h1010, 2'd0, 1'b0, 1'b1);
    drain();

    // Lock bit on entry 1 in M-mode.
    clear_cfg();
    pmp_addr[1] = 32'h40;
    pmp_cfg[1]  = 8'h11;
    issue(32'h40, 2'd1, 1'b1, 1'b1);
    issue(32'h40, 2'd3, 1'b1, 1'b1);
    drain();
    pmp_cfg[1] = 8'h91;
    issue(32'h40, 2'd1, 1'b1, 1'b1);
    issue(32'h40, 2'd0, 1'b1, 1'b1);
    issue(32'h40, 2'd3, 1'b0, 1'b1);
    drain();

    // Reset mid-walk at idx 7: the aborted request gets no response.
    clear_cfg();
    issue(32'h1000, 2'd0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_walk_state", 32'(dbg_state), 32'(WALK));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    repeat (20) @(negedge clk);

    // NAPOT wrap: all-ones entry 0 covers the whole space.
    pmp_addr[0] = '1;
    pmp_cfg[0]  = 8'h19;
    repeat (6) issue($urandom, 2'd0, 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Random configurations and requests over a small address window.
    for (int c = 0; c < 6; c++) begin
      drain();
      for (int k = 0; k < NE; k++) begin
        pmp_cfg[k]  = 8'($urandom_range(0, 255)) & 8'h9F;
        pmp_addr[k] = 32'($urandom_range(0, 63));
      end
      for (int r = 0; r < 25; r++)
        issue(32'($urandom_range(0, 70)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1);
    end

    drain();
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
